instr_decode_stage: RTL and testbench

Registered, parametrised RV32I instruction decode stage with a valid/ready handshake on both sides and an internal decoded-entry buffer of configurable depth. It sits between fetch and the register-file/execute stage of the core. It replaces the purely combinational decoder. It adds:
- sign extension of the immediate to XLEN
- illegal-opcode flagging
- PC carry-through
- back-pressure buffering
- pipeline flush

---
 rtl/instr_decode_stage.sv | 137 +++++++++++++
 tb/tb_instr_decode_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: decodes at push, buffers decoded entries in a circular FIFO,
// and presents the head entry with a valid/ready handshake on both sides.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  entry_t             dec;
  entry_t             head;
  logic signed [31:0] imm32;
  logic               legal;
  logic               push;
  logic               pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    imm32 = '0;
    legal = 1'b1;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {instr[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      7'b0110011, 7'b0001111:
        imm32 = '0;
      default:
        legal = 1'b0;
    endcase
    if (instr[1:0] != 2'b11) legal = 1'b0;
    if (!legal) imm32 = '0;

    dec.opcode  = instr[6:0];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    // signed cast widens by replicating bit 31, covering the XLEN=64 U-type case
    dec.imm     = XLEN'(imm32);
    dec.pc      = pc_in;
    dec.illegal = !legal;
  end

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= dec;
  end

  // empty stage presents all-zero fields rather than stale slot contents
  assign head    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign opcode  = head.opcode;
  assign funct3  = head.funct3;
  assign funct7  = head.funct7;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign rd      = head.rd;
  assign imm     = head.imm;
  assign pc_out  = head.pc;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: two instances (XLEN=32/DEPTH=2 and XLEN=64/DEPTH=3),
// each with a queue-based reference model and a monitor that pops on every handshake.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        illegal;
  } exp_t;

  logic clk;
  logic armed;
  int   n_checks;
  int   n_pass;

  logic        rst_a       [2];
  logic        flush_a     [2];
  logic        in_valid_a  [2];
  logic        in_ready_a  [2];
  logic [31:0] instr_a     [2];
  logic [63:0] pc_in_a     [2];
  logic        out_valid_a [2];
  logic        out_ready_a [2];
  logic [6:0]  opcode_a    [2];
  logic [2:0]  funct3_a    [2];
  logic [6:0]  funct7_a    [2];
  logic [4:0]  rs1_a       [2];
  logic [4:0]  rs2_a       [2];
  logic [4:0]  rd_a        [2];
  logic [63:0] imm_a       [2];
  logic [63:0] pc_out_a    [2];
  logic        illegal_a   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference decode straight from the ISA immediate rules, using integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc, input int xlen);
    exp_t   r;
    longint v;
    logic   legal;
    r.opcode = w[6:0];
    r.funct3 = w[14:12];
    r.funct7 = w[31:25];
    r.rs1    = w[19:15];
    r.rs2    = w[24:20];
    r.rd     = w[11:7];
    r.pc     = pc;
    v        = 0;
    legal = (w[1:0] == 2'b11) &&
            (w[6:0] inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                            7'b0001111});
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        v = w[31:20];
        if (w[31]) v -= 4096;
      end
      7'b0100011: begin
        v = {w[31:25], w[11:7]};
        if (w[31]) v -= 4096;
      end
      7'b1100011: begin
        v = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (w[31]) v -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        v = {w[31:12], 12'b0};
        if (w[31]) v -= (longint'(1) << 32);
      end
      7'b1101111: begin
        v = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (w[31]) v -= (longint'(1) << 21);
      end
      default: v = 0;
    endcase
    if (!legal) v = 0;
    r.imm     = v;
    r.illegal = !legal;
    if (xlen == 32) begin
      r.imm[63:32] = '0;
      r.pc[63:32]  = '0;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int XL = (g == 0) ? 32 : 64;
    localparam int DP = (g == 0) ? 2 : 3;
    logic [XL-1:0] pc_w, imm_w, pc_out_w;
    exp_t          sb_q[$];
    bit            pop_pend;
    exp_t          act;
    exp_t          e;

    assign pc_w        = pc_in_a[g][XL-1:0];
    assign imm_a[g]    = 64'(imm_w);
    assign pc_out_a[g] = 64'(pc_out_w);

    instr_decode_stage #(.XLEN(XL), .DEPTH(DP)) u_dut (
      .clk       (clk),
      .reset     (rst_a[g]),
      .flush     (flush_a[g]),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .instr     (instr_a[g]),
      .pc_in     (pc_w),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .opcode    (opcode_a[g]),
      .funct3    (funct3_a[g]),
      .funct7    (funct7_a[g]),
      .rs1       (rs1_a[g]),
      .rs2       (rs2_a[g]),
      .rd        (rd_a[g]),
      .imm       (imm_w),
      .pc_out    (pc_out_w),
      .illegal   (illegal_a[g])
    );

    // Model: the queue holds exactly the entries the stage should be holding.
    always @(posedge clk) begin
      if (rst_a[g] || flush_a[g]) sb_q.delete();
      else if (in_valid_a[g] && (sb_q.size() + int'(pop_pend)) < DP)
        sb_q.push_back(ref_decode(instr_a[g], pc_in_a[g], XL));
      pop_pend = 1'b0;
    end

    always @(negedge clk) begin
      if (armed) begin
        act = {opcode_a[g], funct3_a[g], funct7_a[g], rs1_a[g], rs2_a[g], rd_a[g],
               imm_a[g], pc_out_a[g], illegal_a[g]};
        chk($sformatf("dut%0d_in_ready", g), in_ready_a[g], sb_q.size() < DP);
        chk($sformatf("dut%0d_out_valid", g), out_valid_a[g], sb_q.size() != 0);
        if (sb_q.size() == 0) begin
          chk($sformatf("dut%0d_empty_fields", g), act, '0);
        end else if (out_valid_a[g] && out_ready_a[g] && !flush_a[g] && !rst_a[g]) begin
          e = sb_q.pop_front();
          chk($sformatf("dut%0d_head", g), act, e);
          pop_pend = 1'b1;
        end
      end
    end
  end

  logic [6:0] legal_ops [11];
  logic [63:0] exp_imm [3];

  task automatic rand_run(input int g, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if ($urandom_range(7, 0) != 0) w[6:0] = legal_ops[$urandom_range(10, 0)];
      in_valid_a[g]  = ($urandom_range(3, 0) != 0);
      instr_a[g]     = w;
      pc_in_a[g]     = {$urandom, $urandom};
      out_ready_a[g] = ($urandom_range(3, 0) != 0);
      flush_a[g]     = ($urandom_range(63, 0) == 0);
      rst_a[g]       = ($urandom_range(255, 0) == 0);
      step();
    end
    in_valid_a[g]  = 1'b0;
    flush_a[g]     = 1'b0;
    rst_a[g]       = 1'b0;
    out_ready_a[g] = 1'b1;
    repeat (5) step();
    out_ready_a[g] = 1'b0;
  endtask

  initial begin
    legal_ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
    exp_imm   = '{64'hFFFF_FFFF, 64'hFFFF_FFFC, 64'h0000_0800};
    n_checks = 0;
    n_pass   = 0;
    armed    = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rst_a[g]       = 1'b1;
      flush_a[g]     = 1'b0;
      in_valid_a[g]  = 1'b0;
      instr_a[g]     = '0;
      pc_in_a[g]     = '0;
      out_ready_a[g] = 1'b0;
    end
    repeat (3) step();
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    armed    = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready_a[0], 1'b1);
    chk("reset_out_valid", out_valid_a[0], 1'b0);
    chk("reset_imm_pc", {imm_a[0], pc_out_a[0], illegal_a[0]}, '0);

    // R-type decode, one-cycle latency
    step();
    in_valid_a[0] = 1'b1; instr_a[0] = 32'h4155_08B3; pc_in_a[0] = 64'h100;
    step();
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    chk("r_out_valid", out_valid_a[0], 1'b1);
    chk("r_funct7", funct7_a[0], 7'h20);
    chk("r_rs2", rs2_a[0], 5'd21);
    chk("r_rs1", rs1_a[0], 5'd10);
    chk("r_funct3", funct3_a[0], 3'd0);
    chk("r_rd", rd_a[0], 5'd17);
    chk("r_opcode", opcode_a[0], 7'h33);
    chk("r_imm_illegal", {imm_a[0], illegal_a[0]}, '0);
    step();
    out_ready_a[0] = 1'b1;
    step();
    out_ready_a[0] = 1'b0;

    // back-to-back addi / beq / jal at full throughput
    out_ready_a[0] = 1'b1;
    in_valid_a[0] = 1'b1; instr_a[0] = 32'hFFF0_0093; pc_in_a[0] = 64'h110;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin instr_a[0] = 32'hFE00_0EE3; pc_in_a[0] = 64'h114; end
      else if (i == 1) begin instr_a[0] = 32'h0010_00EF; pc_in_a[0] = 64'h118; end
      else in_valid_a[0] = 1'b0;
      @(negedge clk);
      chk($sformatf("stream_valid_%0d", i), out_valid_a[0], 1'b1);
      chk($sformatf("stream_imm_%0d", i), imm_a[0], exp_imm[i]);
    end
    step();

    // back-pressure: third push held off until space frees
    out_ready_a[0] = 1'b0;
    in_valid_a[0] = 1'b1; instr_a[0] = 32'h0030_0113; pc_in_a[0] = 64'h200;
    step();
    instr_a[0] = 32'h0040_0193; pc_in_a[0] = 64'h204;
    step();
    instr_a[0] = 32'h0050_0213; pc_in_a[0] = 64'h208;
    @(negedge clk);
    chk("bp_full", in_ready_a[0], 1'b0);
    step();
    @(negedge clk);
    chk("bp_still_full", in_ready_a[0], 1'b0);
    step();
    out_ready_a[0] = 1'b1;
    step();
    @(negedge clk);
    chk("bp_reopen", in_ready_a[0], 1'b1);
    step();
    in_valid_a[0] = 1'b0;
    step();
    @(negedge clk);
    chk("bp_drained", out_valid_a[0], 1'b0);

    // flush with two buffered and a push presented
    step();
    out_ready_a[0] = 1'b0;
    in_valid_a[0] = 1'b1; instr_a[0] = 32'h0010_0093; pc_in_a[0] = 64'h300;
    step();
    pc_in_a[0] = 64'h304;
    step();
    pc_in_a[0] = 64'h308; flush_a[0] = 1'b1;
    step();
    flush_a[0] = 1'b0; in_valid_a[0] = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid_a[0], 1'b0);
    chk("flush_in_ready", in_ready_a[0], 1'b1);
    step();
    out_ready_a[0] = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("flush_no_ghost", {out_valid_a[0], pc_out_a[0]}, '0);
    step();
    out_ready_a[0] = 1'b0;

    // illegal all-zero word, then reset while buffered
    in_valid_a[0] = 1'b1; instr_a[0] = 32'h0; pc_in_a[0] = 64'h400;
    step();
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    chk("illegal_flag", {out_valid_a[0], illegal_a[0]}, 2'b11);
    chk("illegal_imm", imm_a[0], '0);
    step();
    rst_a[0] = 1'b1;
    step();
    rst_a[0] = 1'b0;
    @(negedge clk);
    chk("midstream_reset", out_valid_a[0], 1'b0);

    // XLEN=64 lui sign extension and PC carry
    step();
    in_valid_a[1] = 1'b1; instr_a[1] = 32'h8000_0537; pc_in_a[1] = 64'h1_0000_0000;
    step();
    in_valid_a[1] = 1'b0;
    @(negedge clk);
    chk("x64_lui_imm", imm_a[1], 64'hFFFF_FFFF_8000_0000);
    chk("x64_lui_rd", rd_a[1], 5'd10);
    chk("x64_pc_out", pc_out_a[1], 64'h1_0000_0000);
    step();
    out_ready_a[1] = 1'b1;
    step();
    out_ready_a[1] = 1'b0;

    rand_run(0, 2000);
    rand_run(1, 10000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
